// File: rtl/fetch_unit.sv
// Instruction fetch initiator: issues 1-cycle-latency icache reads into a credit-checked fetch queue feeding decode.
// Optional FETCH_PERF_EN macro adds bundle/stall/redirect performance counters.
package uarch_pkg;
  localparam int FETCH_WIDTH   = 2;
  localparam int CPU_ADDR_BITS = 32;
endpackage

module fetch_unit
  import uarch_pkg::*;
#(
  parameter logic [CPU_ADDR_BITS-1:0] RESET_PC = '0,
  parameter int                       FQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [CPU_ADDR_BITS-1:0]    icache_addr,
  output logic                        icache_re,
  input  logic [FETCH_WIDTH*32-1:0]   icache_dout,
  input  logic                        icache_dout_val,
  output logic                        icache_stall,
  input  logic                        redirect_val,
  input  logic [CPU_ADDR_BITS-1:0]    redirect_pc,
  output logic                        fq_val,
  input  logic                        fq_rdy,
  output logic [FETCH_WIDTH*32-1:0]   fq_bundle,
  output logic [CPU_ADDR_BITS-1:0]    fq_pc,
  output logic [31:0]                 perf_bundles,
  output logic [31:0]                 perf_stalls,
  output logic [31:0]                 perf_redirects
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int BW = FETCH_WIDTH * 32;
  localparam logic [CPU_ADDR_BITS-1:0] PC_STEP = CPU_ADDR_BITS'(4 * FETCH_WIDTH);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(FQ_DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic                     active;
  logic                     inflight;
  logic                     kill;
  logic [CPU_ADDR_BITS-1:0] pc;
  logic [CPU_ADDR_BITS-1:0] pc_inflight;
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            wr_ptr;
  logic [PW:0]              count;

  logic [BW-1:0]            bundle_mem [FQ_DEPTH];
  logic [CPU_ADDR_BITS-1:0] pc_mem     [FQ_DEPTH];

  logic [PW+1:0]            credit_used;
  logic                     issue;
  logic                     wr_en;
  logic                     pop;

  // Credits cover queued entries plus the one response that may still land; pops this cycle are not counted.
  assign credit_used = {1'b0, count} + {{(PW+1){1'b0}}, inflight};
  assign issue       = active & ~redirect_val & (credit_used < DEPTH_W);
  assign wr_en       = icache_dout_val & inflight & ~kill & ~redirect_val;
  assign pop         = fq_val & fq_rdy & ~redirect_val;

  assign icache_re    = issue;
  assign icache_addr  = pc;
  assign icache_stall = 1'b0;

  assign fq_val    = (count != '0);
  assign fq_bundle = fq_val ? bundle_mem[rd_ptr] : '0;
  assign fq_pc     = fq_val ? pc_mem[rd_ptr]     : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active      <= 1'b0;
      inflight    <= 1'b0;
      kill        <= 1'b0;
      pc          <= RESET_PC;
      pc_inflight <= '0;
    end else begin
      active <= 1'b1;
      if (redirect_val) begin
        pc       <= {redirect_pc[CPU_ADDR_BITS-1:2], 2'b00};
        kill     <= inflight;
        inflight <= 1'b0;
      end else begin
        kill     <= 1'b0;
        inflight <= issue;
        if (issue) begin
          pc          <= pc + PC_STEP;
          pc_inflight <= pc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_val) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: reads are masked by fq_val.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bundle_mem[wr_ptr] <= icache_dout;
      pc_mem[wr_ptr]     <= pc_inflight;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] bundles_q;
  logic [31:0] stalls_q;
  logic [31:0] redirects_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundles_q   <= '0;
      stalls_q    <= '0;
      redirects_q <= '0;
    end else begin
      if (wr_en)                                bundles_q   <= bundles_q + 32'd1;
      if (active & ~redirect_val & ~icache_re)  stalls_q    <= stalls_q + 32'd1;
      if (redirect_val)                         redirects_q <= redirects_q + 32'd1;
    end
  end

  assign perf_bundles   = bundles_q;
  assign perf_stalls    = stalls_q;
  assign perf_redirects = redirects_q;
`else
  assign perf_bundles   = '0;
  assign perf_stalls    = '0;
  assign perf_redirects = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: 1-cycle icache responder plus a queue-based reference model, directed phases then random traffic.
module tb_fetch_unit;
  import uarch_pkg::*;

  localparam int DEPTH = 4;
  localparam int BW    = FETCH_WIDTH * 32;
  localparam logic [CPU_ADDR_BITS-1:0] RPC = 32'h100;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [CPU_ADDR_BITS-1:0] icache_addr;
  logic                     icache_re;
  logic [BW-1:0]            icache_dout;
  logic                     icache_dout_val;
  logic                     icache_stall;
  logic                     redirect_val;
  logic [CPU_ADDR_BITS-1:0] redirect_pc;
  logic                     fq_val;
  logic                     fq_rdy;
  logic [BW-1:0]            fq_bundle;
  logic [CPU_ADDR_BITS-1:0] fq_pc;
  logic [31:0]              perf_bundles;
  logic [31:0]              perf_stalls;
  logic [31:0]              perf_redirects;

  fetch_unit #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_addr(icache_addr), .icache_re(icache_re),
    .icache_dout(icache_dout), .icache_dout_val(icache_dout_val),
    .icache_stall(icache_stall),
    .redirect_val(redirect_val), .redirect_pc(redirect_pc),
    .fq_val(fq_val), .fq_rdy(fq_rdy), .fq_bundle(fq_bundle), .fq_pc(fq_pc),
    .perf_bundles(perf_bundles), .perf_stalls(perf_stalls), .perf_redirects(perf_redirects)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0]            b;
    logic [CPU_ADDR_BITS-1:0] pc;
  } ent_t;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  ent_t                     q[$];
  logic [CPU_ADDR_BITS-1:0] m_pc, m_pci, m_prev_addr;
  bit                       m_active, m_inflight, m_kill, m_prev_re;
  logic [31:0]              p_bun, p_stall, p_red;

  // Sampled DUT outputs of the latest cycle, for directed checks
  bit                       s_re, s_val;
  logic [CPU_ADDR_BITS-1:0] s_addr, s_pc;
  int                       cyc = 0, issued = 0, first_re = -1, first_val = -1;
  logic [CPU_ADDR_BITS-1:0] addr_seen[$];

  function automatic logic [BW-1:0] mem_data(input logic [CPU_ADDR_BITS-1:0] a);
    logic [BW-1:0] d;
    for (int l = 0; l < FETCH_WIDTH; l++)
      d[l*32 +: 32] = (a + 32'(4 * l)) ^ 32'hC0DE_5A00;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    q.delete();
    m_pc = RPC; m_pci = '0;
    m_active = 0; m_inflight = 0; m_kill = 0;
    p_bun = 0; p_stall = 0; p_red = 0;
  endtask

  // Entered at posedge+1; drives one cycle, checks outputs, advances model, returns at next posedge+1.
  task automatic do_cycle(input bit rdy, input bit rv, input logic [CPU_ADDR_BITS-1:0] rpc);
    bit e_re, e_val, wr, pop;
    icache_dout_val = m_prev_re;
    icache_dout     = m_prev_re ? mem_data(m_prev_addr) : '0;
    fq_rdy = rdy; redirect_val = rv; redirect_pc = rpc;
    #1;
    e_re  = rst_n && m_active && !rv && (q.size() + int'(m_inflight) < DEPTH);
    e_val = q.size() != 0;
    chk("icache_re", BW'(icache_re), BW'(e_re));
    chk("icache_addr", BW'(icache_addr), BW'(m_pc));
    chk("fq_val", BW'(fq_val), BW'(e_val));
    chk("fq_bundle", fq_bundle, e_val ? q[0].b : '0);
    chk("fq_pc", BW'(fq_pc), e_val ? BW'(q[0].pc) : '0);
    chk("icache_stall", BW'(icache_stall), '0);
`ifdef FETCH_PERF_EN
    chk("perf_bundles", BW'(perf_bundles), BW'(p_bun));
    chk("perf_stalls", BW'(perf_stalls), BW'(p_stall));
    chk("perf_redirects", BW'(perf_redirects), BW'(p_red));
`else
    chk("perf_bundles", BW'(perf_bundles), '0);
    chk("perf_stalls", BW'(perf_stalls), '0);
    chk("perf_redirects", BW'(perf_redirects), '0);
`endif
    s_re = icache_re; s_val = fq_val; s_addr = icache_addr; s_pc = fq_pc;
    if (s_re && first_re < 0) first_re = cyc;
    if (s_val && first_val < 0) first_val = cyc;
    if (s_re) begin issued++; addr_seen.push_back(s_addr); end

    if (!rst_n) reset_model();
    else begin
      wr  = icache_dout_val && m_inflight && !m_kill;
      pop = e_val && rdy;
      if (m_active && !rv && !e_re) p_stall++;
      if (rv) begin
        q.delete();
        m_kill = m_inflight; m_inflight = 0;
        m_pc = {rpc[CPU_ADDR_BITS-1:2], 2'b00};
        p_red++;
      end else begin
        if (pop) void'(q.pop_front());
        if (wr) begin q.push_back('{b: mem_data(m_pci), pc: m_pci}); p_bun++; end
        if (e_re) begin m_pci = m_pc; m_pc = m_pc + 32'(4 * FETCH_WIDTH); end
        m_inflight = e_re; m_kill = 0;
      end
      m_active = 1;
    end
    m_prev_re = icache_re; m_prev_addr = icache_addr;
    cyc++;
    @(posedge clk); #1;
  endtask

  initial begin
    int r;
    rst_n = 0; fq_rdy = 0; redirect_val = 0; redirect_pc = '0;
    icache_dout = '0; icache_dout_val = 0;
    m_prev_re = 0; m_prev_addr = '0;
    reset_model();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_re", BW'(icache_re), '0);
    chk("rst_addr", BW'(icache_addr), BW'(RPC));
    chk("rst_fq_val", BW'(fq_val), '0);
    chk("rst_fq_bundle", fq_bundle, '0);
    chk("rst_fq_pc", BW'(fq_pc), '0);
    chk("rst_perf", BW'(perf_bundles | perf_stalls | perf_redirects), '0);

    // Startup sequence and latency
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 8; i++) do_cycle(1, 0, '0);
    chk("first_re_cycle", BW'(first_re), BW'(1));
    chk("req_to_val", BW'(first_val - first_re), BW'(2));
    chk("addr0", BW'(addr_seen[0]), BW'(32'h100));
    chk("addr1", BW'(addr_seen[1]), BW'(32'h108));
    chk("addr2", BW'(addr_seen[2]), BW'(32'h110));

    // Redirect while in flight, coinciding with pop and response write
    chk("pre_redirect_busy", BW'(s_re && s_val), BW'(1));
    do_cycle(1, 1, 32'h203);
    do_cycle(1, 0, '0);
    chk("redir_addr", BW'(s_addr), BW'(32'h200));
    chk("redir_re", BW'(s_re), BW'(1));
    chk("redir_flush", BW'(s_val), '0);
    do_cycle(1, 0, '0);
    chk("redir_stale_drop", BW'(s_val), '0);
    do_cycle(1, 0, '0);
    chk("redir_target_val", BW'(s_val), BW'(1));
    chk("redir_target_pc", BW'(s_pc), BW'(32'h200));

    // Backpressure: exactly DEPTH bundles accepted, then drain
    do_cycle(0, 1, 32'h1000);
    issued = 0;
    for (int i = 0; i < 12; i++) do_cycle(0, 0, '0);
    chk("full_issued", BW'(issued), BW'(DEPTH));
    chk("full_no_req", BW'(s_re), '0);
    for (int i = 0; i < 10; i++) do_cycle(1, 0, '0);

    // Asynchronous reset with 3 entries queued
    do_cycle(0, 1, 32'h2000);
    r = 0;
    while (q.size() != 3 && r < 20) begin do_cycle(0, 0, '0); r++; end
    chk("fill3", BW'(q.size()), BW'(3));
    rst_n = 0;
    #1;
    chk("arst_fq_val", BW'(fq_val), '0);
    chk("arst_re", BW'(icache_re), '0);
    chk("arst_addr", BW'(icache_addr), BW'(RPC));
    reset_model();
    @(posedge clk); #1;
    do_cycle(1, 0, '0);
    rst_n = 1;
    addr_seen.delete();
    for (int i = 0; i < 6; i++) do_cycle(1, 0, '0);
    chk("restart_addr", BW'(addr_seen.size() > 0 ? addr_seen[0] : 32'hFFFF_FFFF), BW'(RPC));

    // Random traffic
    for (int i = 0; i < 400; i++)
      do_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
